// File: rtl/ctrl_seq.sv
// Micro-sequencer for the regA/regB/ALU datapath on the shared tristate bus.
// Accepts one opcode per handshake; all control outputs are registered Moore decodes.
module ctrl_seq (
  input  logic       clk,
  input  logic       grst,
  input  logic       start,
  input  logic [3:0] opcode,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       halted,
  output logic       a_rs1,
  output logic       a_rs2,
  output logic       a_ws1,
  output logic       b_rs1,
  output logic       b_rs2,
  output logic       b_ws1,
  output logic       a_lrst,
  output logic       b_lrst,
  output logic [1:0] alu_op,
  output logic       alu_ws,
  output logic       out_ld
);

  // state  | meaning
  // IDLE   | ready, waiting for start
  // EXEC1  | ALU op settle cycle, alu_op driven, no bus driver
  // EXEC2  | datapath control cycle for the latched opcode
  // DONE   | done pulse (err with it for C/D/E)
  // HALT   | halted until grst
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA   = 4'h1;
  localparam logic [3:0] OP_LDB   = 4'h2;
  localparam logic [3:0] OP_MOVAB = 4'h3;
  localparam logic [3:0] OP_MOVBA = 4'h4;
  localparam logic [3:0] OP_OUTA  = 4'h9;
  localparam logic [3:0] OP_OUTB  = 4'hA;
  localparam logic [3:0] OP_CLRA  = 4'hB;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_op;
  logic [3:0] w_op_nxt;

  logic       r_ready, r_done, r_err, r_halted;
  logic       r_a_rs1, r_a_rs2, r_a_ws1, r_b_rs1, r_b_rs2, r_b_ws1;
  logic       r_a_lrst, r_b_lrst, r_alu_ws, r_out_ld;
  logic [1:0] r_alu_op;

  logic       w_ready, w_done, w_err, w_halted;
  logic       w_a_rs1, w_a_rs2, w_a_ws1, w_b_rs1, w_b_rs2, w_b_ws1;
  logic       w_a_lrst, w_b_lrst, w_alu_ws, w_out_ld;
  logic [1:0] w_alu_op;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= 4'h5) && (op <= 4'h8);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op_nxt    = opcode;
          w_state_nxt = is_alu(opcode) ? S_EXEC1 : S_EXEC2;
        end
      end
      S_EXEC1: w_state_nxt = S_EXEC2;
      S_EXEC2: w_state_nxt = (r_op == OP_HLT) ? S_HALT : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state/opcode so they register alongside them.
  always_comb begin
    w_ready  = (w_state_nxt == S_IDLE);
    w_halted = (w_state_nxt == S_HALT);
    w_done   = (w_state_nxt == S_DONE);
    w_err    = w_done && (w_op_nxt inside {4'hC, 4'hD, 4'hE});
    w_a_rs1  = 1'b0;
    w_a_rs2  = 1'b0;
    w_a_ws1  = 1'b0;
    w_b_rs1  = 1'b0;
    w_b_rs2  = 1'b0;
    w_b_ws1  = 1'b0;
    w_a_lrst = 1'b0;
    w_b_lrst = 1'b0;
    w_alu_ws = 1'b0;
    w_out_ld = 1'b0;
    w_alu_op = 2'b00;
    if (((w_state_nxt == S_EXEC1) || (w_state_nxt == S_EXEC2)) && is_alu(w_op_nxt)) begin
      w_alu_op = w_op_nxt[1:0] - 2'd1;
    end
    if (w_state_nxt == S_EXEC2) begin
      if (is_alu(w_op_nxt)) begin
        w_alu_ws = 1'b1;
        w_a_rs2  = 1'b1;
      end else begin
        case (w_op_nxt)
          OP_LDA:   w_a_rs1 = 1'b1;
          OP_LDB:   w_b_rs1 = 1'b1;
          OP_MOVAB: begin
            w_a_ws1 = 1'b1;
            w_b_rs2 = 1'b1;
          end
          OP_MOVBA: begin
            w_b_ws1 = 1'b1;
            w_a_rs2 = 1'b1;
          end
          OP_OUTA: begin
            w_a_ws1  = 1'b1;
            w_out_ld = 1'b1;
          end
          OP_OUTB: begin
            w_b_ws1  = 1'b1;
            w_out_ld = 1'b1;
          end
          OP_CLRA: w_a_lrst = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_state  <= S_IDLE;
      r_op     <= 4'h0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_halted <= 1'b0;
      r_a_rs1  <= 1'b0;
      r_a_rs2  <= 1'b0;
      r_a_ws1  <= 1'b0;
      r_b_rs1  <= 1'b0;
      r_b_rs2  <= 1'b0;
      r_b_ws1  <= 1'b0;
      r_a_lrst <= 1'b0;
      r_b_lrst <= 1'b0;
      r_alu_ws <= 1'b0;
      r_out_ld <= 1'b0;
      r_alu_op <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_ready  <= w_ready;
      r_done   <= w_done;
      r_err    <= w_err;
      r_halted <= w_halted;
      r_a_rs1  <= w_a_rs1;
      r_a_rs2  <= w_a_rs2;
      r_a_ws1  <= w_a_ws1;
      r_b_rs1  <= w_b_rs1;
      r_b_rs2  <= w_b_rs2;
      r_b_ws1  <= w_b_ws1;
      r_a_lrst <= w_a_lrst;
      r_b_lrst <= w_b_lrst;
      r_alu_ws <= w_alu_ws;
      r_out_ld <= w_out_ld;
      r_alu_op <= w_alu_op;
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign err    = r_err;
  assign halted = r_halted;
  assign a_rs1  = r_a_rs1;
  assign a_rs2  = r_a_rs2;
  assign a_ws1  = r_a_ws1;
  assign b_rs1  = r_b_rs1;
  assign b_rs2  = r_b_rs2;
  assign b_ws1  = r_b_ws1;
  assign a_lrst = r_a_lrst;
  assign b_lrst = r_b_lrst;
  assign alu_ws = r_alu_ws;
  assign out_ld = r_out_ld;
  assign alu_op = r_alu_op;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: expected per-instruction control signatures are queued
// at issue and checked by a monitor on each done pulse; a small datapath model tracks A/B/OUT.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       grst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       ready, done, err, halted;
  logic       a_rs1, a_rs2, a_ws1, b_rs1, b_rs2, b_ws1, a_lrst, b_lrst, alu_ws, out_ld;
  logic [1:0] alu_op;

  ctrl_seq dut (
    .clk(clk), .grst(grst), .start(start), .opcode(opcode),
    .ready(ready), .done(done), .err(err), .halted(halted),
    .a_rs1(a_rs1), .a_rs2(a_rs2), .a_ws1(a_ws1),
    .b_rs1(b_rs1), .b_rs2(b_rs2), .b_ws1(b_ws1),
    .a_lrst(a_lrst), .b_lrst(b_lrst),
    .alu_op(alu_op), .alu_ws(alu_ws), .out_ld(out_ld)
  );

  always #5 clk = ~clk;

  // {a_rs1,a_rs2,a_ws1,b_rs1,b_rs2,b_ws1,a_lrst,b_lrst,alu_ws,out_ld}
  logic [9:0] w_ctrl;
  assign w_ctrl = {a_rs1, a_rs2, a_ws1, b_rs1, b_rs2, b_ws1, a_lrst, b_lrst, alu_ws, out_ld};

  typedef struct {
    logic [9:0] mask;
    logic [9:0] first;
    logic [1:0] aluop;
    logic       err;
    int         cyc;
    int         ctrl_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Datapath model driven by the DUT control lines.
  logic [3:0] m_a = 4'h0, m_b = 4'h0, m_out = 4'h0, imm = 4'h0;
  logic [3:0] w_alu, w_bus;
  always_comb begin
    w_alu = 4'h0;
    case (alu_op)
      2'b00: w_alu = m_a + m_b;
      2'b01: w_alu = m_a - m_b;
      2'b10: w_alu = m_a & m_b;
      default: w_alu = m_a | m_b;
    endcase
    w_bus = 4'h0;
    if (a_ws1) w_bus = m_a;
    else if (b_ws1) w_bus = m_b;
    else if (alu_ws) w_bus = w_alu;
  end

  always @(posedge clk) begin
    if (a_lrst) m_a <= 4'h0;
    else if (a_rs1) m_a <= imm;
    else if (a_rs2) m_a <= w_bus;
    if (b_lrst) m_b <= 4'h0;
    else if (b_rs1) m_b <= imm;
    else if (b_rs2) m_b <= w_bus;
    if (out_ld) m_out <= w_bus;
  end

  // Monitor: accumulate the control activity of each instruction, compare on done.
  logic [9:0] acc_mask, acc_first;
  logic [1:0] acc_alu;
  int acc_cyc, acc_ctrl_cyc;
  initial begin
    exp_t e;
    acc_mask = '0; acc_first = '0; acc_alu = '0; acc_cyc = 0; acc_ctrl_cyc = 0;
    forever begin
      @(negedge clk);
      check("bus_drivers_le1", 32'(($countones({a_ws1, b_ws1, alu_ws}) <= 1)), 32'd1);
      if (grst || halted || ready) begin
        if (ready && !grst)
          check("idle_quiet", 32'({w_ctrl, alu_op, done, err, halted}), 32'd0);
        acc_mask = '0; acc_first = '0; acc_alu = '0; acc_cyc = 0; acc_ctrl_cyc = 0;
      end else begin
        acc_cyc++;
        if (acc_cyc == 1) acc_first = w_ctrl;
        acc_mask = acc_mask | w_ctrl;
        if (w_ctrl != 10'd0) acc_ctrl_cyc++;
        acc_alu = acc_alu | alu_op;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("ctrl_mask",   32'(acc_mask),     32'(e.mask));
            check("first_cycle", 32'(acc_first),    32'(e.first));
            check("alu_op",      32'(acc_alu),      32'(e.aluop));
            check("err",         32'(err),          32'(e.err));
            check("latency",     32'(acc_cyc),      32'(e.cyc));
            check("ctrl_cycles", 32'(acc_ctrl_cyc), 32'(e.ctrl_cyc));
          end
          acc_mask = '0; acc_first = '0; acc_alu = '0; acc_cyc = 0; acc_ctrl_cyc = 0;
        end else begin
          check("err_without_done", 32'(err), 32'd0);
        end
      end
    end
  end

  task automatic wait_ready();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [9:0] mask, input logic [1:0] aluop, input logic isalu,
                      input logic e_err);
    exp_t e;
    e.mask     = mask;
    e.first    = isalu ? 10'd0 : mask;
    e.aluop    = aluop;
    e.err      = e_err;
    e.cyc      = isalu ? 3 : 2;
    e.ctrl_cyc = (mask != 10'd0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic run(input logic [3:0] op, input logic [3:0] im, input logic [9:0] mask,
                     input logic [1:0] aluop, input logic isalu, input logic e_err,
                     input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eo);
    push(mask, aluop, isalu, e_err);
    wait_ready();
    imm    = im;
    opcode = op;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    check("model_A",   32'(m_a),   32'(ea));
    check("model_B",   32'(m_b),   32'(eb));
    check("model_OUT", 32'(m_out), 32'(eo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 grst = 1'b1;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_outs",  32'({done, err, halted, w_ctrl, alu_op}), 32'd0);
    repeat (3) @(negedge clk);
    #1 grst = 1'b0;

    //  op    imm   mask           aluop isalu err   A     B     OUT
    run(4'h0, 4'h0, 10'b0000000000, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    run(4'h1, 4'h9, 10'b1000000000, 2'd0, 1'b0, 1'b0, 4'h9, 4'h0, 4'h0);
    run(4'h2, 4'h8, 10'b0001000000, 2'd0, 1'b0, 1'b0, 4'h9, 4'h8, 4'h0);
    run(4'h5, 4'h0, 10'b0100000010, 2'd0, 1'b1, 1'b0, 4'h1, 4'h8, 4'h0);
    run(4'h6, 4'h0, 10'b0100000010, 2'd1, 1'b1, 1'b0, 4'h9, 4'h8, 4'h0);
    run(4'h7, 4'h0, 10'b0100000010, 2'd2, 1'b1, 1'b0, 4'h8, 4'h8, 4'h0);
    run(4'h2, 4'h3, 10'b0001000000, 2'd0, 1'b0, 1'b0, 4'h8, 4'h3, 4'h0);
    run(4'h8, 4'h0, 10'b0100000010, 2'd3, 1'b1, 1'b0, 4'hB, 4'h3, 4'h0);
    run(4'h3, 4'h0, 10'b0010100000, 2'd0, 1'b0, 1'b0, 4'hB, 4'hB, 4'h0);
    run(4'h1, 4'h2, 10'b1000000000, 2'd0, 1'b0, 1'b0, 4'h2, 4'hB, 4'h0);
    run(4'h9, 4'h0, 10'b0010000001, 2'd0, 1'b0, 1'b0, 4'h2, 4'hB, 4'h2);
    run(4'h4, 4'h0, 10'b0100010000, 2'd0, 1'b0, 1'b0, 4'hB, 4'hB, 4'h2);
    run(4'hA, 4'h0, 10'b0000010001, 2'd0, 1'b0, 1'b0, 4'hB, 4'hB, 4'hB);
    run(4'hB, 4'h0, 10'b0000001000, 2'd0, 1'b0, 1'b0, 4'h0, 4'hB, 4'hB);
    run(4'hC, 4'h0, 10'b0000000000, 2'd0, 1'b0, 1'b1, 4'h0, 4'hB, 4'hB);
    run(4'hD, 4'h0, 10'b0000000000, 2'd0, 1'b0, 1'b1, 4'h0, 4'hB, 4'hB);
    run(4'hE, 4'h0, 10'b0000000000, 2'd0, 1'b0, 1'b1, 4'h0, 4'hB, 4'hB);

    // Back-to-back LDB 5 then MOVBA with start held high.
    push(10'b0001000000, 2'd0, 1'b0, 1'b0);
    push(10'b0100010000, 2'd0, 1'b0, 1'b0);
    wait_ready();
    imm    = 4'h5;
    opcode = 4'h2;
    start  = 1'b1;
    @(posedge clk);
    #1 opcode = 4'h4;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (ready) break;
    end
    check("b2b_ready_gap", 32'(n), 32'd3);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_accepted", 32'(ready), 32'd0);
    wait_done();
    check("b2b_A", 32'(m_a), 32'h5);
    check("b2b_B", 32'(m_b), 32'h5);

    // HLT, then start pulses are ignored until grst.
    wait_ready();
    opcode = 4'hF;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) begin
        n = 1;
        break;
      end
    end
    check("hlt_reached", 32'(n), 32'd1);
    check("hlt_ready",   32'(ready), 32'd0);
    opcode = 4'h1;
    for (int i = 0; i < 10; i++) begin
      start = ~start;
      @(negedge clk);
      check("hlt_hold", 32'({halted, ready, done, w_ctrl, alu_op}), 32'({1'b1, 14'd0}));
    end
    start = 1'b0;
    #1 grst = 1'b1;
    #1;
    check("hlt_grst_ready",  32'(ready),  32'd1);
    check("hlt_grst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    #1 grst = 1'b0;

    // grst in the middle of MOVAB's EXEC2: bus lines drop asynchronously, no done.
    wait_ready();
    opcode = 4'h3;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("movab_exec2", 32'({a_ws1, b_rs2}), 32'd3);
    #1 grst = 1'b1;
    #1;
    check("movab_async_drop", 32'({a_ws1, b_rs2}), 32'd0);
    check("movab_async_ready", 32'(ready), 32'd1);
    @(negedge clk);
    #1 grst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_state", 32'({ready, done, halted}), 32'd4);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
